arm_mul_unit: RTL and testbench
===============================

Name: arm_mul_unit

Overview:
Parametrised multicycle integer multiply/multiply-accumulate unit for the multicycle ARM core. It succeeds the single long-multiply flag path and covers MUL, MLA, UMULL, SMULL, UMLAL and SMLAL. Operand width and bits retired per cycle are configurable. The controller drives it through a start/busy/done handshake and stalls the core until done, then writes back result_lo/result_hi.

Parameters:
WIDTH, 32, operand width in bits; must be even and at least 8.
STEP, 1, multiplier bits retired per RUN cycle; must divide WIDTH; legal values 1, 2, 4.

Ports:
clk  input  1  core clock, rising edge.
reset  input  1  asynchronous, active-low; asserted when 0.
start  input  1  request; sampled only in IDLE or DONE.
op  input  2  00 MUL (low half), 01 UMULL, 10 SMULL, 11 reserved (executes as UMULL).
acc_en  input  1  add {acc_hi,acc_lo} to the product (MLA/UMLAL/SMLAL).
a  input  WIDTH  multiplicand (Rn/Rm per decode).
b  input  WIDTH  multiplier.
acc_lo  input  WIDTH  accumulator low word.
acc_hi  input  WIDTH  accumulator high word; ignored when op=00.
busy  output  1  high in RUN and FIX.
done  output  1  one-cycle pulse; results valid.
result_lo  output  WIDTH  product low word.
result_hi  output  WIDTH  product high word; 0 when op=00.
flag_n  output  1  N flag for the S-suffixed variant.
flag_z  output  1  Z flag for the S-suffixed variant.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE. All outputs and internal registers are cleared to 0. Any in-flight operation is discarded and no done pulse is issued.
- FSM states: IDLE, RUN, FIX, DONE.
  - IDLE -start-> RUN.
  - RUN stays for WIDTH/STEP cycles, then goes to FIX.
  - FIX lasts 1 cycle, then goes to DONE.
  - DONE -start-> RUN; otherwise DONE -> IDLE.
- Capture on accepted start:
  - a, b, op, acc_en, acc_hi and acc_lo are registered.
  - For SMULL, a and b are replaced by their magnitudes, and neg = a[W-1]^b[W-1] is stored.
  - The 2*WIDTH partial-sum register is cleared and the step counter is loaded with WIDTH/STEP.
- RUN: each cycle adds the STEP least-significant multiplier bits times the multiplicand into the partial sum (unsigned shift-add). The multiplier shifts right by STEP and the counter decrements. RUN exits when the counter reaches 1.
- FIX:
  - If neg, the product is two's-complement negated over 2*WIDTH bits.
  - If acc_en, the accumulator is added modulo 2^(2*WIDTH). For op=00 only acc_lo is used, zero-extended.
  - result_lo/result_hi and the flags are registered. For op=00, result_hi is forced to 0.
- Flags:
  - flag_n = result_hi[W-1] for long ops, result_lo[W-1] for op=00.
  - flag_z = 1 iff the full result is zero: 2*WIDTH bits for long ops, WIDTH bits for op=00.
- Latency: start accepted at edge t gives done=1 in cycle t+WIDTH/STEP+2. With WIDTH=32, STEP=1 that is 34 cycles.
- done is high exactly for the DONE cycle. result_* and flag_* hold their values until the FIX of the next operation or until reset.
- busy=1 in RUN and FIX only. done and busy are never both high.
- start while busy is ignored; the operation in flight completes unchanged.
- start in the DONE cycle is accepted (back-to-back). The done pulse still fires for the completed operation.
- Inputs are not required to be stable after the accepted start cycle.
- Signed corner case: SMULL of the most-negative value by the most-negative value gives 2^(2W-2). The magnitude fits in WIDTH bits unsigned, so no overflow path is needed.

Decomposition:
- Package arm_mul_pkg holds:
  - the op encodings MUL_LO=2'b00, MUL_U=2'b01, MUL_S=2'b10;
  - the FSM state enum {IDLE, RUN, FIX, DONE};
  - a localparam-style function for cycle latency, WIDTH/STEP+2, used by the bench.
- One sub-module is natural: arm_mul_step, combinational. It takes the partial sum, the multiplicand and STEP multiplier bits and returns the next partial sum. This isolates the radix choice.
- The core's controller/datapath integrate the unit. Its done pulse gates RegWrite for RdHi/RdLo.

Test Plan:
1. WIDTH=32, STEP=1, op=00, a=7, b=6, acc_en=0 -> done 34 cycles after start; result_lo=42, result_hi=0, flag_n=0, flag_z=0, busy high for cycles 1..33.
2. op=01, a=b=0xFFFFFFFF -> result_hi=0xFFFFFFFE, result_lo=0x00000001, flag_n=1.
3. op=10, a=0xFFFFFFFE (-2), b=3 -> result_hi=0xFFFFFFFF, result_lo=0xFFFFFFFA, flag_n=1. Then a=b=0x80000000 -> result_hi=0x40000000, result_lo=0.
4. op=01, acc_en=1, a=b=1, acc_hi=1, acc_lo=0xFFFFFFFF -> result_hi=2, result_lo=0. Then op=10, acc_en=1, a=0xFFFFFFFF, b=1, acc_hi=0, acc_lo=1 -> result_hi=0, result_lo=0, flag_z=1.
5. Pulse start again at cycle 10 of a running op with different operands -> ignored; original result delivered at cycle 34. start asserted in the DONE cycle -> second done exactly 34 cycles later.
6. Drive reset=0 at cycle 15 of an op -> busy=done=result_*=flags=0 immediately, no done pulse. With STEP=4, MUL 0x1234*0x10 -> result_lo=0x12340, done after 10 cycles.

Source files
------------

// File: rtl/arm_mul_pkg.sv
// Shared encodings, FSM states and latency helper for the multicycle multiply unit.
package arm_mul_pkg;

    // Operation encodings; 2'b11 is reserved and runs as an unsigned long multiply.
    localparam logic [1:0] MUL_LO = 2'b00;
    localparam logic [1:0] MUL_U  = 2'b01;
    localparam logic [1:0] MUL_S  = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX,
        DONE
    } mul_state_e;

    // Cycles from an accepted start to the done pulse.
    function automatic int unsigned mul_latency(input int unsigned width,
                                                input int unsigned step);
        return width / step + 2;
    endfunction

endpackage

// File: rtl/arm_mul_step.sv
// One shift-add step: folds STEP multiplier bits times the multiplicand into the partial sum.
module arm_mul_step #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned STEP  = 1
) (
    input  logic [2*WIDTH-1:0] psum_i,
    input  logic [2*WIDTH-1:0] mcand_i,
    input  logic [STEP-1:0]    bits_i,
    output logic [2*WIDTH-1:0] psum_o
);

    // Each set multiplier bit contributes the multiplicand shifted to its weight.
    always_comb begin
        psum_o = psum_i;
        for (int j = 0; j < int'(STEP); j++) begin
            if (bits_i[j]) begin
                psum_o = psum_o + (mcand_i << j);
            end
        end
    end

endmodule

// File: rtl/arm_mul_unit.sv
// Multicycle MUL/MLA/UMULL/SMULL/UMLAL/SMLAL unit with a start/busy/done handshake.
module arm_mul_unit
    import arm_mul_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned STEP  = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic             acc_en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] acc_lo,
    input  logic [WIDTH-1:0] acc_hi,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             flag_n,
    output logic             flag_z
);

    localparam int unsigned NSteps = WIDTH / STEP;
    localparam int unsigned CntW   = $clog2(NSteps + 1);
    localparam logic [CntW-1:0] CntInit = CntW'(NSteps);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);

    mul_state_e state_q, state_d;

    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [2*WIDTH-1:0] psum_q, psum_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [WIDTH-1:0]   acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0]   acc_hi_q, acc_hi_d;
    logic [1:0]         op_q, op_d;
    logic               acc_en_q, acc_en_d;
    logic               neg_q, neg_d;
    logic [WIDTH-1:0]   res_lo_q, res_lo_d;
    logic [WIDTH-1:0]   res_hi_q, res_hi_d;
    logic               flag_n_q, flag_n_d;
    logic               flag_z_q, flag_z_d;

    logic               accept;
    logic               is_signed;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [2*WIDTH-1:0] psum_step;
    logic [2*WIDTH-1:0] prod, acc_ext, sum;
    logic               is_long;

    assign accept = start && (state_q == IDLE || state_q == DONE);

    // SMULL runs the unsigned array on magnitudes; the sign is restored in FIX.
    assign is_signed = (op == MUL_S);
    assign a_mag     = (is_signed && a[WIDTH-1]) ? -a : a;
    assign b_mag     = (is_signed && b[WIDTH-1]) ? -b : b;

    arm_mul_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_step (
        .psum_i  (psum_q),
        .mcand_i (mcand_q),
        .bits_i  (mplier_q[STEP-1:0]),
        .psum_o  (psum_step)
    );

    // Final sign fix-up and accumulate; MUL uses only acc_lo, zero-extended.
    always_comb begin
        is_long = (op_q != MUL_LO);
        prod    = neg_q ? -psum_q : psum_q;
        acc_ext = is_long ? {acc_hi_q, acc_lo_q} : {{WIDTH{1'b0}}, acc_lo_q};
        sum     = prod + (acc_en_q ? acc_ext : '0);
    end

    // Next-state logic for the controller and datapath registers.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        psum_d   = psum_q;
        mplier_d = mplier_q;
        acc_lo_d = acc_lo_q;
        acc_hi_d = acc_hi_q;
        op_d     = op_q;
        acc_en_d = acc_en_q;
        neg_d    = neg_q;
        res_lo_d = res_lo_q;
        res_hi_d = res_hi_q;
        flag_n_d = flag_n_q;
        flag_z_d = flag_z_q;

        unique case (state_q)
            IDLE: begin
                if (start) state_d = RUN;
            end
            RUN: begin
                psum_d   = psum_step;
                mcand_d  = mcand_q << STEP;
                mplier_d = mplier_q >> STEP;
                cnt_d    = cnt_q - CntOne;
                if (cnt_q == CntOne) state_d = FIX;
            end
            FIX: begin
                res_lo_d = sum[WIDTH-1:0];
                res_hi_d = is_long ? sum[2*WIDTH-1:WIDTH] : '0;
                flag_n_d = is_long ? sum[2*WIDTH-1] : sum[WIDTH-1];
                flag_z_d = is_long ? (sum == '0) : (sum[WIDTH-1:0] == '0);
                state_d  = DONE;
            end
            DONE: begin
                state_d = start ? RUN : IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Operand capture; results stay untouched until the next FIX.
        if (accept) begin
            cnt_d    = CntInit;
            psum_d   = '0;
            mcand_d  = {{WIDTH{1'b0}}, a_mag};
            mplier_d = b_mag;
            neg_d    = is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
            op_d     = op;
            acc_en_d = acc_en;
            acc_lo_d = acc_lo;
            acc_hi_d = acc_hi;
        end
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            psum_q   <= '0;
            mplier_q <= '0;
            acc_lo_q <= '0;
            acc_hi_q <= '0;
            op_q     <= '0;
            acc_en_q <= 1'b0;
            neg_q    <= 1'b0;
            res_lo_q <= '0;
            res_hi_q <= '0;
            flag_n_q <= 1'b0;
            flag_z_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            psum_q   <= psum_d;
            mplier_q <= mplier_d;
            acc_lo_q <= acc_lo_d;
            acc_hi_q <= acc_hi_d;
            op_q     <= op_d;
            acc_en_q <= acc_en_d;
            neg_q    <= neg_d;
            res_lo_q <= res_lo_d;
            res_hi_q <= res_hi_d;
            flag_n_q <= flag_n_d;
            flag_z_q <= flag_z_d;
        end
    end

    assign busy      = (state_q == RUN) || (state_q == FIX);
    assign done      = (state_q == DONE);
    assign result_lo = res_lo_q;
    assign result_hi = res_hi_q;
    assign flag_n    = flag_n_q;
    assign flag_z    = flag_z_q;

endmodule

// File: tb/tb_arm_mul_unit.sv
// Bench for arm_mul_unit: STEP=1 and STEP=4 instances share stimulus; a cycle-level
// reference model is checked every cycle, plus directed literal checks.
module tb_arm_mul_unit;
    import arm_mul_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic        acc_en;
    logic [31:0] a, b, acc_lo, acc_hi;

    logic        busy_w   [2];
    logic        done_w   [2];
    logic [31:0] res_lo_w [2];
    logic [31:0] res_hi_w [2];
    logic        fn_w     [2];
    logic        fz_w     [2];

    int n_cmp  = 0;
    int n_fail = 0;

    // Cycles spent in RUN per instance.
    int nsteps [2] = '{32, 8};

    always #5 clk = ~clk;

    arm_mul_unit #(.WIDTH(32), .STEP(1)) u_dut0 (
        .clk(clk), .reset(reset), .start(start), .op(op), .acc_en(acc_en),
        .a(a), .b(b), .acc_lo(acc_lo), .acc_hi(acc_hi),
        .busy(busy_w[0]), .done(done_w[0]), .result_lo(res_lo_w[0]),
        .result_hi(res_hi_w[0]), .flag_n(fn_w[0]), .flag_z(fz_w[0])
    );

    arm_mul_unit #(.WIDTH(32), .STEP(4)) u_dut1 (
        .clk(clk), .reset(reset), .start(start), .op(op), .acc_en(acc_en),
        .a(a), .b(b), .acc_lo(acc_lo), .acc_hi(acc_hi),
        .busy(busy_w[1]), .done(done_w[1]), .result_lo(res_lo_w[1]),
        .result_hi(res_hi_w[1]), .flag_n(fn_w[1]), .flag_z(fz_w[1])
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Architectural result {n, z, hi, lo} computed with plain 64-bit arithmetic.
    function automatic logic [65:0] model_res(input logic [1:0] o, input logic ae,
                                              input logic [31:0] ia, input logic [31:0] ib,
                                              input logic [31:0] ih, input logic [31:0] il);
        logic [63:0] p, acc, s;
        if (o == 2'b10) p = {{32{ia[31]}}, ia} * {{32{ib[31]}}, ib};
        else            p = {32'd0, ia} * {32'd0, ib};
        acc = (o == 2'b00) ? {32'd0, il} : {ih, il};
        s   = p + (ae ? acc : 64'd0);
        if (o == 2'b00) return {s[31], s[31:0] == 32'd0, 32'd0, s[31:0]};
        return {s[63], s == 64'd0, s[63:32], s[31:0]};
    endfunction

    // Model: phase 0 idle, 1..N+1 busy, N+2 the done cycle.
    int          m_p    [2];
    logic [65:0] m_pend [2];
    logic [65:0] m_res  [2];

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int d = 0; d < 2; d++) begin
                m_p[d]    <= 0;
                m_pend[d] <= '0;
                m_res[d]  <= '0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (m_p[d] == nsteps[d] + 1) m_res[d] <= m_pend[d];
                if (m_p[d] == 0 || m_p[d] == nsteps[d] + 2) begin
                    if (start) begin
                        m_p[d]    <= 1;
                        m_pend[d] <= model_res(op, acc_en, a, b, acc_hi, acc_lo);
                    end else begin
                        m_p[d] <= 0;
                    end
                end else begin
                    m_p[d] <= m_p[d] + 1;
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            check($sformatf("busy%0d", d), 64'(busy_w[d]),
                  64'(m_p[d] >= 1 && m_p[d] <= nsteps[d] + 1));
            check($sformatf("done%0d", d), 64'(done_w[d]), 64'(m_p[d] == nsteps[d] + 2));
            check($sformatf("result_lo%0d", d), 64'(res_lo_w[d]), 64'(m_res[d][31:0]));
            check($sformatf("result_hi%0d", d), 64'(res_hi_w[d]), 64'(m_res[d][63:32]));
            check($sformatf("flag_z%0d", d), 64'(fz_w[d]), 64'(m_res[d][64]));
            check($sformatf("flag_n%0d", d), 64'(fn_w[d]), 64'(m_res[d][65]));
        end
    end

    // Drive a start in the current cycle, then scramble inputs after acceptance.
    task automatic issue(input logic [1:0] o, input logic ae, input logic [31:0] ia,
                         input logic [31:0] ib, input logic [31:0] ih, input logic [31:0] il);
        op = o; acc_en = ae; a = ia; b = ib; acc_hi = ih; acc_lo = il;
        start = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        op     = 2'($urandom);
        acc_en = 1'($urandom);
        a      = $urandom;
        b      = $urandom;
        acc_hi = $urandom;
        acc_lo = $urandom;
    endtask

    task automatic run_op(input logic [1:0] o, input logic ae, input logic [31:0] ia,
                          input logic [31:0] ib, input logic [31:0] ih, input logic [31:0] il);
        @(posedge clk); #1;
        issue(o, ae, ia, ib, ih, il);
    endtask

    // Bounded wait for done on instance d; lat counts the cycle index since start.
    task automatic wait_done(input int d, input int first, output int lat, output int nb);
        lat = first;
        nb  = 0;
        while (!done_w[d] && lat < 100) begin
            if (busy_w[d]) nb++;
            @(posedge clk); #1;
            lat++;
        end
        if (!done_w[d]) check($sformatf("timeout%0d", d), 64'(0), 64'(1));
    endtask

    task automatic check_res(input string tag, input int d, input logic [31:0] hi,
                             input logic [31:0] lo, input logic n, input logic z);
        check({tag, "_hi"}, 64'(res_hi_w[d]), 64'(hi));
        check({tag, "_lo"}, 64'(res_lo_w[d]), 64'(lo));
        check({tag, "_n"}, 64'(fn_w[d]), 64'(n));
        check({tag, "_z"}, 64'(fz_w[d]), 64'(z));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, nb, seen;
        reset = 1'b0; start = 1'b0; op = '0; acc_en = 1'b0;
        a = '0; b = '0; acc_lo = '0; acc_hi = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 64'(busy_w[0]), 64'(0));
        check("reset_done", 64'(done_w[0]), 64'(0));
        check_res("reset", 0, 32'd0, 32'd0, 1'b0, 1'b0);
        reset = 1'b1;

        check("latency_fn", 64'(mul_latency(32, 1)), 64'(34));

        // MUL 7*6
        run_op(2'b00, 1'b0, 32'd7, 32'd6, 32'd0, 32'd0);
        wait_done(0, 1, lat, nb);
        check("mul_latency", 64'(lat), 64'(34));
        check("mul_busy_cycles", 64'(nb), 64'(33));
        check_res("mul", 0, 32'd0, 32'd42, 1'b0, 1'b0);

        // UMULL all-ones squared
        run_op(2'b01, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0);
        wait_done(0, 1, lat, nb);
        check_res("umull", 0, 32'hFFFF_FFFE, 32'h0000_0001, 1'b1, 1'b0);

        // SMULL -2*3 and most-negative squared
        run_op(2'b10, 1'b0, 32'hFFFF_FFFE, 32'd3, 32'd0, 32'd0);
        wait_done(0, 1, lat, nb);
        check_res("smull_neg", 0, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b1, 1'b0);
        run_op(2'b10, 1'b0, 32'h8000_0000, 32'h8000_0000, 32'd0, 32'd0);
        wait_done(0, 1, lat, nb);
        check_res("smull_min", 0, 32'h4000_0000, 32'd0, 1'b0, 1'b0);

        // UMLAL carry into high word, SMLAL to zero
        run_op(2'b01, 1'b1, 32'd1, 32'd1, 32'd1, 32'hFFFF_FFFF);
        wait_done(0, 1, lat, nb);
        check_res("umlal", 0, 32'd2, 32'd0, 1'b0, 1'b0);
        run_op(2'b10, 1'b1, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd1);
        wait_done(0, 1, lat, nb);
        check_res("smlal_zero", 0, 32'd0, 32'd0, 1'b0, 1'b1);

        // MLA ignores acc_hi; reserved op runs as UMULL
        run_op(2'b00, 1'b1, 32'h0001_0000, 32'h0001_0000, 32'hFFFF_FFFF, 32'd5);
        wait_done(0, 1, lat, nb);
        check_res("mla", 0, 32'd0, 32'd5, 1'b0, 1'b0);
        run_op(2'b11, 1'b1, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0F0F_0F0F, 32'hF0F0_F0F0);
        wait_done(0, 1, lat, nb);

        // Start while busy is ignored; start in DONE is accepted
        run_op(2'b00, 1'b0, 32'd100, 32'd3, 32'd0, 32'd0);
        repeat (9) begin @(posedge clk); #1; end
        issue(2'b00, 1'b0, 32'd9, 32'd9, 32'd0, 32'd0);
        wait_done(0, 11, lat, nb);
        check("ignored_start_latency", 64'(lat), 64'(34));
        check_res("ignored_start", 0, 32'd0, 32'd300, 1'b0, 1'b0);
        issue(2'b01, 1'b0, 32'd5, 32'd11, 32'd0, 32'd0);
        wait_done(0, 1, lat, nb);
        check("b2b_latency", 64'(lat), 64'(34));
        check_res("b2b", 0, 32'd0, 32'd55, 1'b0, 1'b0);

        // Asynchronous reset mid-operation
        run_op(2'b01, 1'b0, 32'hFFFF_FFFF, 32'd3, 32'd0, 32'd0);
        repeat (14) begin @(posedge clk); #1; end
        reset = 1'b0;
        #1;
        check("rst_busy", 64'(busy_w[0]), 64'(0));
        check("rst_done", 64'(done_w[0]), 64'(0));
        check_res("rst", 0, 32'd0, 32'd0, 1'b0, 1'b0);
        @(posedge clk); #1;
        reset = 1'b1;
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done_w[0]) seen = 1;
        end
        check("rst_no_done", 64'(seen), 64'(0));

        // Radix-16 instance
        run_op(2'b00, 1'b0, 32'h0000_1234, 32'h0000_0010, 32'd0, 32'd0);
        wait_done(1, 1, lat, nb);
        check("step4_latency", 64'(lat), 64'(10));
        check_res("step4", 1, 32'd0, 32'h0001_2340, 1'b0, 1'b0);
        wait_done(0, lat, lat, nb);

        @(posedge clk); #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
